// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC, req/ack fetch FSM (IDLE/REQ/DROP) and an instruction FIFO.
// Defining IFU_MISALIGN_TRAP_EN enables the misaligned-redirect trap (misalign output).
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] Inst,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  output logic        misalign,
  output logic [1:0]  dbg_state
);
  // Handshake: imem_req/imem_addr are held until a cycle with imem_ack high; the
  // transfer completes on that rising edge. Consumer pops the head on inst_valid && !stall.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      inst_mem_q [FIFO_DEPTH];
  logic [31:0]      inst_mem_d [FIFO_DEPTH];
  logic [31:0]      pc_mem_q   [FIFO_DEPTH];
  logic [31:0]      pc_mem_d   [FIFO_DEPTH];

  logic             acked, push, pop;
  logic [31:0]      tgt_pc;
  logic             trap_hold;

`ifdef IFU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign tgt_pc     = redirect_pc;
  assign trap_hold  = misalign_q;
  assign misalign_d = redirect ? (|redirect_pc[1:0]) : misalign_q;
  assign misalign   = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign tgt_pc    = {redirect_pc[31:2], 2'b00};
  assign trap_hold = 1'b0;
  assign misalign  = 1'b0;
`endif

  assign inst_valid = (count_q != '0);
  assign Inst       = inst_mem_q[rd_ptr_q];
  assign pc_out     = pc_mem_q[rd_ptr_q];
  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;

    acked = req_q && imem_ack;
    pop   = inst_valid && !stall;
    push  = (state_q == S_REQ) && acked && !redirect;

    if (push) begin
      inst_mem_d[wr_ptr_q] = imem_rdata;
      pc_mem_d[wr_ptr_q]   = addr_q;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (redirect) begin
      // Flush wins over any same-cycle push/pop; an unacked fetch must still complete.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = tgt_pc;
      if (req_q && !imem_ack) begin
        state_d = S_DROP;
      end else begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!trap_hold && (count_d < DEPTH_C)) begin
            state_d = S_REQ;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
          end
        end
        S_REQ: begin
          if (acked) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            // count_d already holds this push, so it also reserves the next fetch slot.
            if (count_d < DEPTH_C) begin
              state_d = S_REQ;
              req_d   = 1'b1;
              addr_d  = fetch_pc_q + 32'd4;
            end else begin
              state_d = S_IDLE;
              req_d   = 1'b0;
            end
          end
        end
        S_DROP: begin
          if (acked) begin
            if (trap_hold) begin
              state_d = S_IDLE;
              req_d   = 1'b0;
            end else begin
              state_d = S_REQ;
              req_d   = 1'b1;
              addr_d  = fetch_pc_q;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= RESET_PC;
      end
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

endmodule
